// File: rtl/hetic_pkg.sv
// hetic_pkg: shared candidate type and width/stage helpers for the HETI arbiter
package hetic_pkg;
  function automatic int irq_width(int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction
  function automatic int prio_width(int prios);
    return (prios > 1) ? $clog2(prios) : 1;
  endfunction
  function automatic int num_stages(int levels, int pipe_every);
    return (pipe_every == 0) ? 0 : (levels - 1) / pipe_every;
  endfunction
  function automatic bit is_stage(int k, int levels, int pipe_every);
    return pipe_every != 0 && k > 0 && k < levels && k % pipe_every == 0;
  endfunction
  localparam int DefIrqWidth = irq_width(64);
  localparam int DefPrioWidth = prio_width(32);
  typedef struct packed {
    logic                    valid;
    logic [DefIrqWidth-1:0]  id;
    logic [DefPrioWidth-1:0] prio;
    logic                    heti;
    logic                    nest;
  } irq_cand_t;
endpackage

// File: rtl/hetic_arbiter_if.sv
// hetic_arbiter_if: per-line interrupt state in, core-facing request out
interface hetic_arbiter_if
  import hetic_pkg::*;
#(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32
);
  localparam int IrqWidth = irq_width(NrIrqLines);
  localparam int PrioWidth = prio_width(NrIrqPrios);
  logic [NrIrqLines-1:0]           ie_i;
  logic [NrIrqLines-1:0]           ip_i;
  logic [NrIrqLines*PrioWidth-1:0] prio_i;
  logic [NrIrqLines-1:0]           heti_i;
  logic [NrIrqLines-1:0]           nest_i;
  logic [PrioWidth-1:0]            threshold_i;
  logic                            irq_ack_i;
  logic                            irq_valid_o;
  logic [IrqWidth-1:0]             irq_id_o;
  logic [PrioWidth-1:0]            irq_level_o;
  logic                            irq_heti_o;
  logic                            irq_nest_o;
  modport master (
    output ie_i, ip_i, prio_i, heti_i, nest_i, threshold_i, irq_ack_i,
    input  irq_valid_o, irq_id_o, irq_level_o, irq_heti_o, irq_nest_o
  );
  modport slave (
    input  ie_i, ip_i, prio_i, heti_i, nest_i, threshold_i, irq_ack_i,
    output irq_valid_o, irq_id_o, irq_level_o, irq_heti_o, irq_nest_o
  );
endinterface

// File: rtl/hetic_arbiter_node.sv
// hetic_arb_node: two-input priority compare, the left (lower id) input wins ties
module hetic_arb_node
  import hetic_pkg::*;
#(
  parameter type cand_t = irq_cand_t
) (
  input  cand_t a,
  input  cand_t b,
  output cand_t y
);
  assign y = (b.valid && (!a.valid || b.prio > a.prio)) ? b : (a.valid ? a : '0);
endmodule

// File: rtl/hetic_arbiter.sv
// hetic_arbiter: pipelined priority tree driving the core interrupt request with post-claim blanking
module hetic_arbiter
  import hetic_pkg::*;
#(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int PipeEvery  = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  hetic_arbiter_if.slave bus
);
  localparam int IrqWidth = irq_width(NrIrqLines);
  localparam int PrioWidth = prio_width(NrIrqPrios);
  localparam int Levels = IrqWidth;
  localparam int Stages = num_stages(Levels, PipeEvery);
  localparam int BlankWidth = $clog2(Stages + 3);
  localparam logic [BlankWidth-1:0] BlankLoad = BlankWidth'(Stages + 2);
  typedef struct packed {
    logic                 valid;
    logic [IrqWidth-1:0]  id;
    logic [PrioWidth-1:0] prio;
    logic                 heti;
    logic                 nest;
  } cand_t;
  for (genvar k = 0; k <= Levels; k++) begin : g_lvl
    localparam int W = NrIrqLines >> k;
    cand_t c [W];
    cand_t q [W];
    for (genvar n = 0; n < W; n++) begin : g_n
      if (k == 0) begin : g_leaf
        logic v;
        assign v = bus.ie_i[n] & bus.ip_i[n];
        assign c[n] = v ? cand_t'{valid: 1'b1, id: IrqWidth'(n),
                                  prio: bus.prio_i[n*PrioWidth +: PrioWidth],
                                  heti: bus.heti_i[n], nest: bus.nest_i[n]} : '0;
      end else begin : g_node
        hetic_arb_node #(.cand_t(cand_t)) u_node (
          .a(g_lvl[k-1].q[2*n]),
          .b(g_lvl[k-1].q[2*n+1]),
          .y(c[n])
        );
      end
    end
    if (is_stage(k, Levels, PipeEvery)) begin : g_stage
      always_ff @(posedge clk_i) begin
        if (!rst_ni) q <= '{default: '0};
        else q <= c;
      end
    end else begin : g_wire
      assign q = c;
    end
  end
  cand_t                 root;
  logic                  valid_q;
  logic [IrqWidth-1:0]   id_q;
  logic [PrioWidth-1:0]  prio_q;
  logic                  heti_q;
  logic                  nest_q;
  logic [BlankWidth-1:0] blank_cnt;
  assign root = g_lvl[Levels].q[0];
  // threshold and blanking act here so they bypass the tree latency
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      id_q      <= '0;
      prio_q    <= '0;
      heti_q    <= 1'b0;
      nest_q    <= 1'b0;
      blank_cnt <= '0;
    end else begin
      valid_q   <= root.valid && root.prio > bus.threshold_i && blank_cnt == '0 && !bus.irq_ack_i;
      id_q      <= root.id;
      prio_q    <= root.prio;
      heti_q    <= root.heti;
      nest_q    <= root.nest;
      blank_cnt <= bus.irq_ack_i ? BlankLoad : blank_cnt - BlankWidth'(blank_cnt != '0);
    end
  end
  assign bus.irq_valid_o = valid_q;
  assign bus.irq_id_o    = id_q;
  assign bus.irq_level_o = prio_q;
  assign bus.irq_heti_o  = heti_q;
  assign bus.irq_nest_o  = nest_q;
endmodule

// File: tb/tb_hetic_arbiter.sv
// tb_hetic_arbiter: directed vector table plus hand sequences for latency, threshold, ack blanking and reset
module tb_hetic_arbiter;
  localparam int PW = 5;
  typedef struct {
    int a; int pa; int ea;
    int b; int pb; int eb;
    int thr;
    int ev; int eid; int elvl;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t vecs [12];
  always #5 clk = ~clk;
  hetic_arbiter_if #(.NrIrqLines(64), .NrIrqPrios(32)) bus ();
  hetic_arbiter_if #(.NrIrqLines(8), .NrIrqPrios(32)) bus8 ();
  hetic_arbiter #(.NrIrqLines(64), .NrIrqPrios(32), .PipeEvery(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );
  hetic_arbiter #(.NrIrqLines(8), .NrIrqPrios(32), .PipeEvery(0)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus8)
  );
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask
  task automatic clear_all();
    bus.ie_i = '0; bus.ip_i = '0; bus.prio_i = '0;
    bus.threshold_i = '0; bus.irq_ack_i = 1'b0;
    for (int n = 0; n < 64; n++) begin
      bus.heti_i[n] = (n % 2) != 0;
      bus.nest_i[n] = ((n / 2) % 2) != 0;
    end
    bus8.ie_i = '0; bus8.ip_i = '0; bus8.prio_i = '0;
    bus8.heti_i = '0; bus8.nest_i = '0;
    bus8.threshold_i = '0; bus8.irq_ack_i = 1'b0;
  endtask
  task automatic set_line(int n, int p, int e);
    if (n >= 0) begin
      bus.ie_i[n] = e != 0;
      bus.ip_i[n] = 1'b1;
      bus.prio_i[n*PW +: PW] = PW'(p);
    end
  endtask
  task automatic check_out(string nm, int v, int id, int lvl);
    chk({nm, " valid"}, int'(bus.irq_valid_o), v);
    chk({nm, " id"}, int'(bus.irq_id_o), id);
    chk({nm, " level"}, int'(bus.irq_level_o), lvl);
    chk({nm, " heti"}, int'(bus.irq_heti_o), id % 2);
    chk({nm, " nest"}, int'(bus.irq_nest_o), (id / 2) % 2);
  endtask
  initial begin
    vecs[0]  = '{5, 3, 1, -1, 0, 0, 0, 1, 5, 3};
    vecs[1]  = '{7, 10, 1, 40, 10, 1, 0, 1, 7, 10};
    vecs[2]  = '{7, 10, 1, 40, 11, 1, 0, 1, 40, 11};
    vecs[3]  = '{7, 10, 1, 40, 11, 0, 0, 1, 7, 10};
    vecs[4]  = '{2, 4, 1, -1, 0, 0, 4, 0, 2, 4};
    vecs[5]  = '{2, 4, 1, -1, 0, 0, 3, 1, 2, 4};
    vecs[6]  = '{2, 0, 1, -1, 0, 0, 0, 0, 2, 0};
    vecs[7]  = '{63, 31, 1, 0, 31, 1, 0, 1, 0, 31};
    vecs[8]  = '{63, 31, 1, -1, 0, 0, 30, 1, 63, 31};
    vecs[9]  = '{63, 31, 1, -1, 0, 0, 31, 0, 63, 31};
    vecs[10] = '{12, 9, 0, -1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 5, 1, 62, 6, 1, 0, 1, 62, 6};
    clear_all();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ie_i = {$urandom(), $urandom()};
      bus.ip_i = {$urandom(), $urandom()};
      bus.prio_i = {10{$urandom()}};
      bus.threshold_i = PW'($urandom());
      bus.irq_ack_i = 1'($urandom());
    end
    tick(1);
    chk("rst valid", int'(bus.irq_valid_o), 0);
    chk("rst id", int'(bus.irq_id_o), 0);
    chk("rst level", int'(bus.irq_level_o), 0);
    chk("rst blank", int'(dut.blank_cnt), 0);
    bus.irq_ack_i = 1'b0;
    bus.threshold_i = '0;
    rst_n = 1'b1;
    tick(1);
    chk("post rst valid", int'(bus.irq_valid_o), 0);
    chk("post rst id", int'(bus.irq_id_o), 0);
    chk("post rst level", int'(bus.irq_level_o), 0);
    chk("post rst blank", int'(dut.blank_cnt), 0);
    for (int i = 0; i < 12; i++) begin
      clear_all();
      set_line(vecs[i].a, vecs[i].pa, vecs[i].ea);
      set_line(vecs[i].b, vecs[i].pb, vecs[i].eb);
      bus.threshold_i = PW'(vecs[i].thr);
      tick(4);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].elvl);
    end
    clear_all();
    tick(4);
    set_line(5, 3, 1);
    tick(1);
    chk("lat c1 valid", int'(bus.irq_valid_o), 0);
    tick(1);
    chk("lat c2 valid", int'(bus.irq_valid_o), 0);
    tick(1);
    check_out("lat c3", 1, 5, 3);
    bus.heti_i[5] = 1'b0;
    bus.nest_i[5] = 1'b1;
    tick(3);
    chk("track heti", int'(bus.irq_heti_o), 0);
    chk("track nest", int'(bus.irq_nest_o), 1);
    clear_all();
    set_line(2, 4, 1);
    bus.threshold_i = 5'd4;
    tick(4);
    chk("thr eq valid", int'(bus.irq_valid_o), 0);
    bus.threshold_i = 5'd3;
    tick(1);
    chk("thr lat valid", int'(bus.irq_valid_o), 1);
    clear_all();
    set_line(5, 9, 1);
    set_line(9, 2, 1);
    tick(4);
    check_out("pre ack", 1, 5, 9);
    bus.irq_ack_i = 1'b1;
    tick(1);
    bus.irq_ack_i = 1'b0;
    bus.ip_i[5] = 1'b0;
    chk("ack c1 valid", int'(bus.irq_valid_o), 0);
    for (int j = 2; j <= 5; j++) begin
      tick(1);
      chk($sformatf("ack c%0d valid", j), int'(bus.irq_valid_o), 0);
    end
    tick(1);
    check_out("ack c6", 1, 9, 2);
    bus.irq_ack_i = 1'b1;
    tick(1);
    bus.irq_ack_i = 1'b0;
    chk("reack c1 valid", int'(bus.irq_valid_o), 0);
    tick(1);
    chk("reack c2 valid", int'(bus.irq_valid_o), 0);
    bus.irq_ack_i = 1'b1;
    tick(1);
    bus.irq_ack_i = 1'b0;
    for (int j = 3; j <= 7; j++) begin
      chk($sformatf("reack c%0d valid", j), int'(bus.irq_valid_o), 0);
      tick(1);
    end
    check_out("reack c8", 1, 9, 2);
    bus.irq_ack_i = 1'b1;
    set_line(20, 15, 1);
    tick(1);
    bus.irq_ack_i = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("ack+new c%0d valid", j), int'(bus.irq_valid_o), 0);
      tick(1);
    end
    check_out("ack+new c6", 1, 20, 15);
    rst_n = 1'b0;
    tick(1);
    chk("midrst c1 valid", int'(bus.irq_valid_o), 0);
    rst_n = 1'b1;
    tick(1);
    chk("midrst c2 valid", int'(bus.irq_valid_o), 0);
    tick(1);
    chk("midrst c3 valid", int'(bus.irq_valid_o), 0);
    tick(1);
    check_out("midrst c4", 1, 20, 15);
    clear_all();
    tick(1);
    bus8.ie_i[3] = 1'b1;
    bus8.ip_i[3] = 1'b1;
    bus8.prio_i[3*PW +: PW] = 5'd7;
    tick(1);
    chk("p0 lat valid", int'(bus8.irq_valid_o), 1);
    chk("p0 lat id", int'(bus8.irq_id_o), 3);
    chk("p0 lat level", int'(bus8.irq_level_o), 7);
    bus8.ie_i = '0;
    bus8.ip_i = '1;
    bus8.prio_i = '1;
    bus8.heti_i = '1;
    bus8.nest_i = '1;
    tick(1);
    chk("p0 noie valid", int'(bus8.irq_valid_o), 0);
    chk("p0 noie id", int'(bus8.irq_id_o), 0);
    chk("p0 noie level", int'(bus8.irq_level_o), 0);
    chk("p0 noie heti", int'(bus8.irq_heti_o), 0);
    chk("p0 noie nest", int'(bus8.irq_nest_o), 0);
    tick(2);
    chk("p0 noie hold valid", int'(bus8.irq_valid_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
